ram_port_arbiter: RTL and testbench

- Owns the single-port 64 KB main RAM and shares it between three requesters:
  - power-on/reset clear sweep;
  - CPU bus (oricatmos ram_ad/ram_d/ram_we/ram_q);
  - host DMA port, used for snapshot/program injection from ioctl and memory peek.
- Sits between the core, the hps_io glue and the spram instance.
- Replaces the ad-hoc reset-mux in the top level.

---
 rtl/oric_mem_pkg.sv | 20 ++
 rtl/ram_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/oric_mem_pkg.sv
// Shared types and constants for the Oric main-RAM port arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents:
//   RAM_AW      default main RAM address width (64 KB)
//   RAM_FILL    byte written into every location by the power-on clear sweep
//   arb_state_t arbiter states: CLEAR (sweep), IDLE (arbitrate), HOST (host completion)
package oric_mem_pkg;

   localparam int         RAM_AW   = 16;
   localparam logic [7:0] RAM_FILL = 8'h01;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      HOST  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter.sv
// Shares the single-port main RAM between the reset clear sweep, the CPU bus and the host DMA port.
// Latency: request to mem_* 1 clk; read data lands in cpu_q/host_q 3 clks after the request is taken.
// Backpressure: CPU is never stalled (fixed priority); host_req is level and waits for host_ack.
//
// Ports:
//   clk_sys, reset                 single clock, synchronous active-high reset (restarts the sweep)
//   cpu_ce/cpu_addr/cpu_din/cpu_we CPU memory slot, one strobe per >= 4 clocks
//   cpu_q                          CPU read data, held until the next CPU read capture
//   host_req/host_we/host_addr/host_din  host access, level request held until host_ack
//   host_ack/host_q                1-clk completion pulse and host read data
//   clr_busy                       high while the clear sweep runs
//   mem_addr/mem_d/mem_we/mem_q    registered spram interface; mem_q valid 1 clk after mem_addr

// Clear sweep counter. clr_cnt is one bit wider than the address so the MSB
// flags completion and the counter parks there instead of wrapping.
module clear_sweeper
   import oric_mem_pkg::*;
#(
   parameter int ADDR_W = RAM_AW
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              en,
   output logic [ADDR_W-1:0] addr,
   output logic              last,
   output logic              done
);

   logic [ADDR_W:0] clr_cnt;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         clr_cnt <= '0;
      end else if (en && !clr_cnt[ADDR_W]) begin
         clr_cnt <= clr_cnt + (ADDR_W+1)'(1);
      end
   end

   assign addr = clr_cnt[ADDR_W-1:0];
   assign done = clr_cnt[ADDR_W];
   // Final address of the sweep is being issued this clock.
   assign last = !done && (&addr);

endmodule

module ram_port_arbiter
   import oric_mem_pkg::*;
#(
   parameter int         ADDR_W = RAM_AW,
   parameter logic [7:0] FILL   = RAM_FILL
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              cpu_ce,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   input  logic              cpu_we,
   output logic [7:0]        cpu_q,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [7:0]        host_din,
   output logic              host_ack,
   output logic [7:0]        host_q,
   output logic              clr_busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_d,
   output logic              mem_we,
   input  logic [7:0]        mem_q
);

   arb_state_t        state;
   arb_state_t        state_nxt;

   logic              sweep_en;
   logic              cpu_go;
   logic              host_go;

   logic [ADDR_W-1:0] clr_addr;
   logic              clr_last;
   logic              clr_done;

   // Read pipeline: p1 = address on mem_addr, p2 = mem_q valid this clock.
   logic              cpu_rd_p1_vld;
   logic              cpu_rd_p2_vld;
   logic              host_rd_p2_vld;
   logic              host_rd_op;

   clear_sweeper #(
      .ADDR_W (ADDR_W)
   ) u_sweeper (
      .clk_sys (clk_sys),
      .reset   (reset),
      .en      (sweep_en),
      .addr    (clr_addr),
      .last    (clr_last),
      .done    (clr_done)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state <= CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sweep_en  = 1'b0;
      cpu_go    = 1'b0;
      host_go   = 1'b0;
      case (state)
         CLEAR: begin
            sweep_en = 1'b1;
            if (clr_last) begin
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            cpu_go = cpu_ce;
            // Hold off a new host access while the previous read is still in
            // flight or being acked, so a request still held high from the
            // last access is not mistaken for a fresh one.
            host_go = !cpu_ce && host_req && !host_rd_p2_vld && !host_ack;
            if (host_go) begin
               state_nxt = HOST;
            end
         end
         HOST: begin
            // The host access was already issued on entry; this clock stays
            // open for the CPU so a slot landing here is not delayed.
            cpu_go    = cpu_ce;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         mem_addr       <= '0;
         mem_d          <= FILL;
         mem_we         <= 1'b0;
         clr_busy       <= 1'b1;
         cpu_q          <= 8'h00;
         host_q         <= 8'h00;
         host_ack       <= 1'b0;
         host_rd_op     <= 1'b0;
         cpu_rd_p1_vld  <= 1'b0;
         cpu_rd_p2_vld  <= 1'b0;
         host_rd_p2_vld <= 1'b0;
      end else begin
         // Registered so it drops one clock after the last sweep write issues.
         clr_busy <= !clr_done;

         if (sweep_en) begin
            mem_addr <= clr_addr;
            mem_d    <= FILL;
            mem_we   <= 1'b1;
         end else if (cpu_go) begin
            mem_addr <= cpu_addr;
            mem_d    <= cpu_din;
            mem_we   <= cpu_we;
         end else if (host_go) begin
            mem_addr <= host_addr;
            mem_d    <= host_din;
            mem_we   <= host_we;
         end else begin
            mem_we   <= 1'b0;
         end

         if (host_go) begin
            host_rd_op <= !host_we;
         end

         cpu_rd_p1_vld  <= cpu_go && !cpu_we;
         cpu_rd_p2_vld  <= cpu_rd_p1_vld;
         host_rd_p2_vld <= (state == HOST) && host_rd_op;

         if (cpu_rd_p2_vld) begin
            cpu_q <= mem_q;
         end
         if (host_rd_p2_vld) begin
            host_q <= mem_q;
         end

         // Writes ack in the HOST clock; reads ack with the data capture.
         host_ack <= (host_go && host_we) || host_rd_p2_vld;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

   logic        clk_sys;
   logic        reset;
   logic        cpu_ce;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic        cpu_we;
   logic [7:0]  cpu_q;
   logic        host_req;
   logic        host_we;
   logic [15:0] host_addr;
   logic [7:0]  host_din;
   logic        host_ack;
   logic [7:0]  host_q;
   logic        clr_busy;
   logic [15:0] mem_addr;
   logic [7:0]  mem_d;
   logic        mem_we;
   logic [7:0]  mem_q;

   int total = 0;
   int bad   = 0;

   ram_port_arbiter #(
      .ADDR_W (16),
      .FILL   (8'h01)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .cpu_ce    (cpu_ce),
      .cpu_addr  (cpu_addr),
      .cpu_din   (cpu_din),
      .cpu_we    (cpu_we),
      .cpu_q     (cpu_q),
      .host_req  (host_req),
      .host_we   (host_we),
      .host_addr (host_addr),
      .host_din  (host_din),
      .host_ack  (host_ack),
      .host_q    (host_q),
      .clr_busy  (clr_busy),
      .mem_addr  (mem_addr),
      .mem_d     (mem_d),
      .mem_we    (mem_we),
      .mem_q     (mem_q)
   );

   // Synchronous single-port RAM: read data valid one clock after the address.
   logic [7:0] ram [0:65535];
   always @(posedge clk_sys) begin
      if (mem_we) ram[mem_addr] <= mem_d;
      mem_q <= ram[mem_addr];
   end

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; cpu_ce = 1'b0; cpu_addr = 16'h0; cpu_din = 8'h0; cpu_we = 1'b0;
      host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0; host_din = 8'h0;
      tick(); tick(); tick();
      total++; if (clr_busy !== 1'b1) begin bad++; $display("FAIL reset_clr_busy got=%0h exp=1", clr_busy); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%0h exp=0", mem_we); end
      total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
      total++; if (mem_d !== 8'h01) begin bad++; $display("FAIL reset_mem_d got=%0h exp=01", mem_d); end
      total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL reset_host_ack got=%0h exp=0", host_ack); end
      total++; if (cpu_q !== 8'h00) begin bad++; $display("FAIL reset_cpu_q got=%0h exp=00", cpu_q); end
      total++; if (host_q !== 8'h00) begin bad++; $display("FAIL reset_host_q got=%0h exp=00", host_q); end
   endtask

   // Partial sweep, reset mid-sweep, then a full sweep with a host read held throughout.
   task automatic test_sweep_restart();
      int nerr;
      int first_bad;
      bit got;
      host_req = 1'b1; host_we = 1'b0; host_addr = 16'h1234;
      reset = 1'b0;
      nerr = 0; first_bad = -1;
      for (int k = 1; k <= 3000; k++) begin
         tick();
         if (mem_we !== 1'b1 || mem_addr !== 16'(k-1) || mem_d !== 8'h01 || clr_busy !== 1'b1 || host_ack !== 1'b0) begin
            nerr++; if (first_bad < 0) first_bad = k;
         end
      end
      total++; if (nerr != 0) begin bad++; $display("FAIL sweep_partial errors=%0d first_clock=%0d exp errors=0", nerr, first_bad); end

      reset = 1'b1;
      tick();
      total++; if (mem_we !== 1'b0 || mem_addr !== 16'h0000) begin bad++; $display("FAIL midsweep_reset mem_we=%0h mem_addr=%0h exp we=0 addr=0", mem_we, mem_addr); end
      total++; if (clr_busy !== 1'b1 || host_ack !== 1'b0) begin bad++; $display("FAIL midsweep_reset busy=%0h ack=%0h exp busy=1 ack=0", clr_busy, host_ack); end
      reset = 1'b0;

      nerr = 0; first_bad = -1;
      for (int k = 1; k <= 65536; k++) begin
         tick();
         if (mem_we !== 1'b1 || mem_addr !== 16'(k-1) || mem_d !== 8'h01 || clr_busy !== 1'b1 || host_ack !== 1'b0) begin
            nerr++; if (first_bad < 0) first_bad = k;
         end
      end
      total++; if (nerr != 0) begin bad++; $display("FAIL sweep_full errors=%0d first_clock=%0d exp errors=0", nerr, first_bad); end

      tick(); // clock 65537
      total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL sweep_busy_fall got=%0h exp=0", clr_busy); end
      total++; if (mem_addr !== 16'h1234 || mem_we !== 1'b0) begin bad++; $display("FAIL sweep_host_start mem_addr=%0h mem_we=%0h exp 1234/0", mem_addr, mem_we); end

      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         tick();
         if (host_ack === 1'b1) got = 1'b1;
      end
      host_req = 1'b0;
      total++;
      if (!got) begin bad++; $display("FAIL sweep_host_ack got=timeout exp=ack"); end
      else if (host_q !== 8'h01) begin bad++; $display("FAIL sweep_host_q got=%0h exp=01", host_q); end
      tick(); tick();
   endtask

   task automatic test_cpu_rw();
      cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hBB00; cpu_din = 8'h5A;
      tick();
      total++; if (mem_addr !== 16'hBB00 || mem_we !== 1'b1 || mem_d !== 8'h5A) begin bad++; $display("FAIL cpu_wr_issue addr=%0h we=%0h d=%0h exp BB00/1/5A", mem_addr, mem_we, mem_d); end
      cpu_ce = 1'b0; cpu_we = 1'b0;
      tick(); tick(); tick();
      total++; if (cpu_q !== 8'h00) begin bad++; $display("FAIL cpu_wr_no_q got=%0h exp=00", cpu_q); end

      cpu_ce = 1'b1; cpu_addr = 16'hBB00;
      tick();
      total++; if (mem_addr !== 16'hBB00 || mem_we !== 1'b0) begin bad++; $display("FAIL cpu_rd_issue addr=%0h we=%0h exp BB00/0", mem_addr, mem_we); end
      cpu_ce = 1'b0;
      tick();
      total++; if (cpu_q !== 8'h00) begin bad++; $display("FAIL cpu_rd_early got=%0h exp=00", cpu_q); end
      tick();
      total++; if (cpu_q !== 8'h5A) begin bad++; $display("FAIL cpu_rd_data got=%0h exp=5A", cpu_q); end
      tick();

      cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_din = 8'h77;
      tick();
      cpu_ce = 1'b0; cpu_we = 1'b0;
      tick(); tick(); tick();
      total++; if (cpu_q !== 8'h5A) begin bad++; $display("FAIL cpu_q_hold got=%0h exp=5A", cpu_q); end
   endtask

   task automatic test_collision();
      host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0500; host_din = 8'hC3;
      cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
      tick();
      total++; if (mem_addr !== 16'h0400 || mem_we !== 1'b0 || host_ack !== 1'b0) begin bad++; $display("FAIL coll_cpu_first addr=%0h we=%0h ack=%0h exp 0400/0/0", mem_addr, mem_we, host_ack); end
      cpu_ce = 1'b0;
      tick();
      total++; if (mem_addr !== 16'h0500 || mem_we !== 1'b1 || mem_d !== 8'hC3) begin bad++; $display("FAIL coll_host_wr addr=%0h we=%0h d=%0h exp 0500/1/C3", mem_addr, mem_we, mem_d); end
      total++; if (host_ack !== 1'b1) begin bad++; $display("FAIL coll_host_ack got=%0h exp=1", host_ack); end
      host_req = 1'b0;
      tick();
      total++; if (host_ack !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL coll_after ack=%0h we=%0h exp 0/0", host_ack, mem_we); end
      total++; if (cpu_q !== 8'h01) begin bad++; $display("FAIL coll_cpu_rd got=%0h exp=01", cpu_q); end
      tick();
      cpu_ce = 1'b1; cpu_addr = 16'h0500;
      tick();
      cpu_ce = 1'b0;
      tick(); tick();
      total++; if (cpu_q !== 8'hC3) begin bad++; $display("FAIL coll_readback got=%0h exp=C3", cpu_q); end
      tick();
   endtask

   task automatic test_back_to_back();
      bit got;
      bit host_done;
      for (int i = 0; i < 256; i++) begin
         host_we = 1'b1; host_addr = 16'(i); host_din = 8'(i) ^ 8'hA5; host_req = 1'b1;
         got = 1'b0;
         for (int c = 0; c < 8 && !got; c++) begin
            tick();
            if (host_ack === 1'b1) got = 1'b1;
         end
         total++; if (!got) begin bad++; $display("FAIL b2b_wr_ack addr=%0h got=timeout exp=ack", i); end
      end
      host_req = 1'b0;
      tick(); tick();

      host_done = 1'b0;
      fork
         begin
            bit hgot;
            for (int i = 0; i < 256; i++) begin
               host_we = 1'b0; host_addr = 16'(i); host_req = 1'b1;
               hgot = 1'b0;
               for (int c = 0; c < 12 && !hgot; c++) begin
                  tick();
                  if (host_ack === 1'b1) hgot = 1'b1;
               end
               total++;
               if (!hgot) begin bad++; $display("FAIL b2b_rd_ack addr=%0h got=timeout exp=ack", i); end
               else if (host_q !== (8'(i) ^ 8'hA5)) begin bad++; $display("FAIL b2b_rd_data addr=%0h got=%0h exp=%0h", i, host_q, 8'(i) ^ 8'hA5); end
            end
            host_req = 1'b0;
            host_done = 1'b1;
         end
         begin
            logic [15:0] a;
            int n;
            n = 0;
            while (!host_done) begin
               a = 16'h8000 + 16'(n);
               cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = a;
               tick();
               total++; if (mem_addr !== a || mem_we !== 1'b0) begin bad++; $display("FAIL b2b_cpu_slot got=%0h/%0h exp=%0h/0", mem_addr, mem_we, a); end
               cpu_ce = 1'b0;
               tick(); tick();
               total++; if (cpu_q !== 8'h01) begin bad++; $display("FAIL b2b_cpu_q addr=%0h got=%0h exp=01", a, cpu_q); end
               tick();
               n++;
            end
         end
      join
      tick(); tick();
   endtask

   task automatic test_reset_in_host();
      int nerr;
      host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0042;
      tick();
      total++; if (mem_addr !== 16'h0042 || mem_we !== 1'b0) begin bad++; $display("FAIL rsthost_enter addr=%0h we=%0h exp 0042/0", mem_addr, mem_we); end
      reset = 1'b1;
      tick();
      total++; if (host_ack !== 1'b0 || clr_busy !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0000) begin
         bad++; $display("FAIL rsthost_reset ack=%0h busy=%0h we=%0h addr=%0h exp 0/1/0/0", host_ack, clr_busy, mem_we, mem_addr);
      end
      reset = 1'b0; host_req = 1'b0;
      nerr = 0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (host_ack !== 1'b0 || mem_addr !== 16'(k-1) || mem_we !== 1'b1 || clr_busy !== 1'b1) nerr++;
      end
      total++; if (nerr != 0) begin bad++; $display("FAIL rsthost_sweep errors=%0d exp=0", nerr); end
   endtask

   initial begin
      test_reset();
      test_sweep_restart();
      test_cpu_rw();
      test_collision();
      test_back_to_back();
      test_reset_in_host();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
